// File: rtl/snake_tick_input.sv
// Game-step tick generator and debounced button front end for the snake game.
// Emits a one-cycle tick at a programmable period and commits per-player directions on it.
module snake_tick_input #(
    parameter int N_PLAYERS       = 1,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DB_CNT_W        = 18,
    parameter int TICK_BASE       = 12500000,
    parameter int TICK_CNT_W      = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [4*N_PLAYERS-1:0]   btn_n,
    input  logic [1:0]               speed,
    input  logic                     pause,
    output logic                     tick,
    output logic [2*N_PLAYERS-1:0]   dir,
    output logic [N_PLAYERS-1:0]     dir_change,
    output logic [15:0]              tick_count
);

    localparam int NB = 4 * N_PLAYERS;
    localparam logic [DB_CNT_W-1:0]   DB_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_CNT_W-1:0]   DB_ONE  = DB_CNT_W'(1);
    localparam logic [TICK_CNT_W-1:0] BASE    = TICK_CNT_W'(TICK_BASE);
    localparam logic [TICK_CNT_W-1:0] T_ONE   = TICK_CNT_W'(1);
    localparam logic [15:0]           C_ONE   = 16'd1;

    // Last counter value of the current period; the period never drops below one cycle.
    function automatic logic [TICK_CNT_W-1:0] period_last(input logic [1:0] s);
        logic [TICK_CNT_W-1:0] p;
        p = BASE >> s;
        if (p == '0)
            p = T_ONE;
        return p - T_ONE;
    endfunction

    // Button group order is {up, down, left, right}; earlier entries win.
    function automatic logic [1:0] pick_dir(input logic [3:0] p);
        if (p[3])
            return 2'b11;
        else if (p[2])
            return 2'b01;
        else if (p[1])
            return 2'b10;
        return 2'b00;
    endfunction

    logic [NB-1:0]         sync_p0;
    logic [NB-1:0]         sync_p1;
    logic [NB-1:0]         stable;
    logic [NB-1:0]         press;
    logic [DB_CNT_W-1:0]   db_cnt [NB];
    logic [TICK_CNT_W-1:0] tick_cnt;
    logic [1:0]            pend [N_PLAYERS];
    logic [N_PLAYERS-1:0]  pend_vld;
    logic                  fire;

    assign fire = !pause && (tick_cnt >= period_last(speed));

    // Stage p0/p1: two-flop synchroniser, then per-button debounce producing press strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= '1;
            sync_p1 <= '1;
            stable  <= '1;
            press   <= '0;
            for (int b = 0; b < NB; b++)
                db_cnt[b] <= '0;
        end else begin
            sync_p0 <= btn_n;
            sync_p1 <= sync_p0;
            press   <= '0;
            for (int b = 0; b < NB; b++) begin
                if (sync_p1[b] != stable[b]) begin
                    if (db_cnt[b] == DB_LAST) begin
                        stable[b] <= sync_p1[b];
                        db_cnt[b] <= '0;
                        press[b]  <= ~sync_p1[b];
                    end else begin
                        db_cnt[b] <= db_cnt[b] + DB_ONE;
                    end
                end else begin
                    db_cnt[b] <= '0;
                end
            end
        end
    end

    // Tick generation, pending capture and direction commit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt   <= '0;
            tick       <= 1'b0;
            tick_count <= '0;
            dir_change <= '0;
            pend_vld   <= '0;
            for (int p = 0; p < N_PLAYERS; p++) begin
                pend[p]        <= 2'b00;
                dir[2*p +: 2]  <= (p % 2 == 1) ? 2'b10 : 2'b00;
            end
        end else begin
            dir_change <= '0;
            if (pause) begin
                tick <= 1'b0;
            end else if (fire) begin
                tick_cnt   <= '0;
                tick       <= 1'b1;
                tick_count <= tick_count + C_ONE;
            end else begin
                tick_cnt <= tick_cnt + T_ONE;
                tick     <= 1'b0;
            end
            for (int p = 0; p < N_PLAYERS; p++) begin
                // Same or reversed direction is dropped; the request is consumed either way.
                if (fire && pend_vld[p]) begin
                    if (pend[p] != dir[2*p +: 2] && (pend[p] ^ dir[2*p +: 2]) != 2'b10) begin
                        dir[2*p +: 2] <= pend[p];
                        dir_change[p] <= 1'b1;
                    end
                end
                // A press on the commit edge survives for the next tick.
                if (|press[4*p +: 4]) begin
                    pend[p]     <= pick_dir(press[4*p +: 4]);
                    pend_vld[p] <= 1'b1;
                end else if (fire) begin
                    pend_vld[p] <= 1'b0;
                end
            end
        end
    end

endmodule
